// File: rtl/fc_argmax.sv
`default_nettype none
// ============================================================================
//  Module   : fc_argmax
//  Brief    : Running arg-max over a serial stream of NUM_CLASSES signed FC
//             scores. It reports the winning class index and its score
//             together with a done flag.
//  Option   : FC_ARGMAX_TOP2_EN enables runner-up tracking and adds the
//             second_idx and second_score ports.
//  Revision : 1.0 - initial release
// ============================================================================
module fc_argmax #(
  parameter int NUM_CLASSES = 10,
  parameter int SCORE_W     = 38,
  parameter int IDX_W       = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic               score_valid,
  input  logic [SCORE_W-1:0] score_in,
  output logic               score_ready,
  output logic [IDX_W-1:0]   class_idx,
  output logic [SCORE_W-1:0] max_score,
  output logic               done
`ifdef FC_ARGMAX_TOP2_EN
  ,
  output logic [IDX_W-1:0]   second_idx,
  output logic [SCORE_W-1:0] second_score
`endif
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  localparam logic [IDX_W-1:0] C_LAST = IDX_W'(NUM_CLASSES - 1);

  state_t                     r_state;
  state_t                     w_next;
  logic [IDX_W-1:0]           r_cnt;
  logic                       r_ready;
  logic                       r_done;
  logic [IDX_W-1:0]           r_idx;
  logic signed [SCORE_W-1:0]  r_max;
  logic                       w_accept;
  logic                       w_first;
  logic                       w_gt_max;

  assign w_accept = score_valid & r_ready;
  assign w_first  = (r_cnt == '0);
  assign w_gt_max = $signed(score_in) > r_max;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic; dropping enable always returns to idle
  always_comb begin
    w_next = r_state;
    if (!enable) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:    w_next = S_COLLECT;
        S_COLLECT: if (w_accept && (r_cnt == C_LAST)) w_next = S_DONE;
        S_DONE:    w_next = S_DONE;
        default:   w_next = S_IDLE;
      endcase
    end
  end

  // Registered handshake and done flags, derived from the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ready <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_ready <= (w_next == S_COLLECT);
      r_done  <= (w_next == S_DONE);
    end
  end

  // Class counter and running maximum; strict compare keeps the lowest index on ties
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_idx <= '0;
      r_max <= '0;
    end else if (!enable) begin
      r_cnt <= '0;
      r_idx <= '0;
      r_max <= '0;
    end else if (r_state == S_IDLE) begin
      r_cnt <= '0;
    end else if (w_accept) begin
      r_cnt <= r_cnt + IDX_W'(1);
      if (w_first || w_gt_max) begin
        r_max <= $signed(score_in);
        r_idx <= r_cnt;
      end
    end
  end

`ifdef FC_ARGMAX_TOP2_EN
  logic [IDX_W-1:0]          r_sidx;
  logic signed [SCORE_W-1:0] r_second;
  logic                      w_gt_second;

  assign w_gt_second = $signed(score_in) > r_second;

  // Runner-up: a new max demotes the old one; the second accept seeds the slot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sidx   <= '0;
      r_second <= '0;
    end else if (!enable) begin
      r_sidx   <= '0;
      r_second <= '0;
    end else if (w_accept && !w_first) begin
      if (w_gt_max) begin
        r_second <= r_max;
        r_sidx   <= r_idx;
      end else if (w_gt_second || (r_cnt == IDX_W'(1))) begin
        r_second <= $signed(score_in);
        r_sidx   <= r_cnt;
      end
    end
  end

  assign second_idx   = r_sidx;
  assign second_score = r_second;
`endif

  assign score_ready = r_ready;
  assign done        = r_done;
  assign class_idx   = r_idx;
  assign max_score   = r_max;

endmodule
`default_nettype wire

// File: tb/tb_fc_argmax.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fc_argmax
//  Brief    : Directed self-checking bench for fc_argmax.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fc_argmax;

  localparam int N  = 10;
  localparam int SW = 38;
  localparam int IW = 4;

  typedef logic signed [SW-1:0] score_t;

  logic          clk;
  logic          rst_n;
  logic          enable;
  logic          score_valid;
  score_t        score_in;
  logic          score_ready;
  logic [IW-1:0] class_idx;
  score_t        max_score;
  logic          done;
`ifdef FC_ARGMAX_TOP2_EN
  logic [IW-1:0] second_idx;
  score_t        second_score;
`endif

  int     chk_cnt = 0;
  int     err_cnt = 0;
  score_t vec [N];
  int     accepts;
  int     cycles_used;

  fc_argmax #(.NUM_CLASSES(N), .SCORE_W(SW), .IDX_W(IW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .score_valid  (score_valid),
    .score_in     (score_in),
    .score_ready  (score_ready),
    .class_idx    (class_idx),
    .max_score    (max_score),
    .done         (done)
`ifdef FC_ARGMAX_TOP2_EN
    ,
    .second_idx   (second_idx),
    .second_score (second_score)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [63:0] got,
                       input logic signed [63:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Raise enable from idle; the block is in COLLECT after one edge
  task automatic start_frame();
    enable = 1'b1;
    tick();
  endtask

  task automatic drop_enable();
    enable = 1'b0;
    score_valid = 1'b0;
    tick();
  endtask

  // Stream vec[0..n-1]; with gaps, valid is high only on even cycles
  task automatic send_vec(input int n, input bit gaps);
    int  i   = 0;
    int  cyc = 0;
    bit  vld;
    bit  rdy;
    while (i < n && cyc < 200) begin
      vld         = gaps ? (cyc % 2 == 0) : 1'b1;
      score_valid = vld;
      score_in    = vec[i];
      rdy         = score_ready;
      if (vld && rdy && i == N - 1) check("done_before_last", done, 0);
      tick();
      if (vld && rdy) i++;
      cyc++;
    end
    score_valid = 1'b0;
    accepts     = i;
    cycles_used = cyc;
    if (i < n) check("accept_timeout", i, n);
  endtask

  task automatic load_s2();
    vec[0] = 5;  vec[1] = -3; vec[2] = 12; vec[3] = 7; vec[4] = 0;
    vec[5] = 1;  vec[6] = 2;  vec[7] = 3;  vec[8] = 4; vec[9] = 6;
  endtask

  initial begin
    rst_n       = 1'b0;
    enable      = 1'b0;
    score_valid = 1'b0;
    score_in    = '0;
    #1;
    check("rst_done", done, 0);
    check("rst_ready", score_ready, 0);
    check("rst_idx", class_idx, 0);
    check("rst_max", max_score, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Idle ignores valid scores
    score_valid = 1'b1; score_in = 77;
    tick(); tick();
    check("idle_ready", score_ready, 0);
    check("idle_max", max_score, 0);
    score_valid = 1'b0;

    // Async reset in the middle of a frame
    load_s2();
    start_frame();
    check("first_collect_ready", score_ready, 1);
    send_vec(3, 1'b0);
    check("mid_max", max_score, 12);
    #2;
    rst_n = 1'b0;
    enable = 1'b0;
    #1;
    check("async_ready", score_ready, 0);
    check("async_max", max_score, 0);
    check("async_idx", class_idx, 0);
    check("async_done", done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Basic frame
    start_frame();
    send_vec(N, 1'b0);
    check("s2_done", done, 1);
    check("s2_ready", score_ready, 0);
    check("s2_idx", class_idx, 2);
    check("s2_max", max_score, 12);
`ifdef FC_ARGMAX_TOP2_EN
    check("s2_sidx", second_idx, 3);
    check("s2_second", second_score, 7);
`endif
    drop_enable();
    check("clr_done", done, 0);
    check("clr_max", max_score, 0);

    // All equal negative scores, then a tie at 4 and 8
    for (int k = 0; k < N; k++) vec[k] = -100;
    start_frame();
    send_vec(N, 1'b0);
    check("neg_idx", class_idx, 0);
    check("neg_max", max_score, -100);
    drop_enable();
    for (int k = 0; k < N; k++) vec[k] = 0;
    vec[4] = 9; vec[8] = 9;
    start_frame();
    send_vec(N, 1'b0);
    check("tie_idx", class_idx, 4);
    check("tie_max", max_score, 9);
`ifdef FC_ARGMAX_TOP2_EN
    check("tie_sidx", second_idx, 8);
    check("tie_second", second_score, 9);
`endif
    drop_enable();

    // Valid toggling every cycle
    load_s2();
    start_frame();
    send_vec(N, 1'b1);
    check("gap_accepts", accepts, 10);
    check("gap_cycles", cycles_used, 19);
    check("gap_done", done, 1);
    check("gap_idx", class_idx, 2);
    check("gap_max", max_score, 12);
    drop_enable();

    // Abort after six accepts, then a clean frame
    vec[0] = 50; vec[1] = 60; vec[2] = 70; vec[3] = 80; vec[4] = 90; vec[5] = 99;
    start_frame();
    send_vec(6, 1'b0);
    check("pre_abort_max", max_score, 99);
    drop_enable();
    check("abort_done", done, 0);
    check("abort_ready", score_ready, 0);
    check("abort_max", max_score, 0);
    check("abort_idx", class_idx, 0);
    load_s2();
    start_frame();
    send_vec(N, 1'b0);
    check("reuse_idx", class_idx, 2);
    check("reuse_max", max_score, 12);
    drop_enable();

    // Full-scale signed extremes
    for (int k = 0; k < N; k++) vec[k] = 0;
    vec[0] = 38'sh20_0000_0000;
    vec[9] = 38'sh1F_FFFF_FFFF;
    start_frame();
    send_vec(N, 1'b0);
    check("ext_idx", class_idx, 9);
    check("ext_max", max_score, 64'sd137438953471);
`ifdef FC_ARGMAX_TOP2_EN
    check("ext_sidx", second_idx, 1);
    check("ext_second", second_score, 0);
`endif
    // Extra valid scores while done are ignored
    score_valid = 1'b1;
    score_in    = 38'sh1F_FFFF_FFFF;
    repeat (3) tick();
    score_valid = 1'b0;
    check("done_hold", done, 1);
    check("done_ready", score_ready, 0);
    check("done_idx", class_idx, 9);
    check("done_max", max_score, 64'sd137438953471);
    drop_enable();
    check("final_done", done, 0);

    $display("CHECKS %0d ERRORS %0d", chk_cnt, err_cnt);
    $finish;
  end

  // Absolute time guard
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
